inner_fn_sched: RTL and testbench

Stream scheduler for the pipelined inner-function unit, which computes 0.5*x + x^2*cos((x-128)/128) at a fixed latency with no internal stall.
- Accepts a vector command (length N), pulls N single-precision operands from an input stream and issues at most one per cycle into the unit.
- Captures results in a local result FIFO and presents them on a backpressured output stream, marking the last element.
- Credit-based issue: every in-flight result is guaranteed a FIFO slot, so the unit's clock enable never needs gating.

---
 rtl/inner_fn_sched.sv | 164 ++++++++++++++++
 tb/tb_inner_fn_sched.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inner_fn_sched.sv
`default_nettype none
// ============================================================================
// Module      : inner_fn_sched
// Description : Credit-based stream scheduler feeding the fixed-latency
//               inner-function unit and buffering its results in a FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module inner_fn_sched #(
    parameter int PIPE_LATENCY = 15,
    parameter int FIFO_DEPTH   = 16,
    parameter int LEN_W        = 16
) (
    input  logic             clock,
    input  logic             aclr_n,
    input  logic             cmd_start,
    input  logic [LEN_W-1:0] cmd_len,
    output logic             cmd_busy,
    output logic             cmd_done,
    input  logic             in_valid,
    input  logic [31:0]      in_data,
    output logic             in_ready,
    output logic             pipe_aclr,
    output logic             pipe_clk_en,
    output logic             pipe_start,
    output logic [31:0]      pipe_dataa,
    input  logic [31:0]      pipe_result,
    input  logic             pipe_done,
    output logic             out_valid,
    output logic [31:0]      out_data,
    output logic             out_last,
    input  logic             out_ready,
    output logic             err_overflow
);

    localparam int c_addr_w = $clog2(FIFO_DEPTH);
    localparam int c_cnt_w  = c_addr_w + 1;

    generate
        if (FIFO_DEPTH < 2 || PIPE_LATENCY < 1) begin : g_bad_params
            $error("inner_fn_sched: FIFO_DEPTH must be >= 2 and PIPE_LATENCY >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_DRAIN  = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [LEN_W-1:0]     r_len;
    logic [LEN_W-1:0]     r_issued_cnt;
    logic [LEN_W-1:0]     r_popped_cnt;
    logic [c_cnt_w-1:0]   r_inflight;
    logic [c_cnt_w-1:0]   r_count;
    logic [c_addr_w-1:0]  r_wr_ptr;
    logic [c_addr_w-1:0]  r_rd_ptr;
    logic [31:0]          r_mem [FIFO_DEPTH];
    logic                 r_pipe_start;
    logic [31:0]          r_pipe_dataa;
    logic                 r_err;

    logic                 w_issue;
    logic                 w_pop;
    logic                 w_wr;
    logic                 w_full;
    logic                 w_credit_ok;
    logic                 w_last_issue;
    logic                 w_last_pop;
    logic                 w_accept_cmd;
    logic [c_cnt_w:0]     w_occupancy;

    // Occupancy counts results already buffered plus results still in the
    // unit; keeping it below the depth reserves a slot for every issue.
    assign w_occupancy  = {1'b0, r_count} + {1'b0, r_inflight};
    assign w_credit_ok  = w_occupancy < (c_cnt_w + 1)'(FIFO_DEPTH);
    assign w_full       = (r_count == c_cnt_w'(FIFO_DEPTH));

    assign in_ready     = (r_state == S_RUN) && (r_issued_cnt < r_len) && w_credit_ok;
    assign w_issue      = in_valid && in_ready;
    assign w_wr         = pipe_done && (r_inflight != '0) && !w_full;
    assign out_valid    = (r_count != '0);
    assign out_data     = r_mem[r_rd_ptr];
    assign w_pop        = out_valid && out_ready;
    assign out_last     = out_valid && (r_popped_cnt == r_len - LEN_W'(1));
    assign w_last_issue = w_issue && (r_issued_cnt == r_len - LEN_W'(1));
    assign w_last_pop   = w_pop && (r_popped_cnt == r_len - LEN_W'(1));
    assign w_accept_cmd = (r_state == S_IDLE) && cmd_start;

    assign cmd_busy     = (r_state != S_IDLE);
    assign cmd_done     = (r_state == S_FINISH);
    assign pipe_aclr    = ~aclr_n;
    assign pipe_clk_en  = 1'b1;
    assign pipe_start   = r_pipe_start;
    assign pipe_dataa   = r_pipe_dataa;
    assign err_overflow = r_err;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (cmd_start) w_state_nxt = (cmd_len != '0) ? S_RUN : S_FINISH;
            S_RUN:    if (w_last_issue) w_state_nxt = S_DRAIN;
            S_DRAIN:  if (w_last_pop) w_state_nxt = S_FINISH;
            S_FINISH: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!aclr_n) begin
            r_state      <= S_IDLE;
            r_len        <= '0;
            r_issued_cnt <= '0;
            r_popped_cnt <= '0;
            r_inflight   <= '0;
            r_count      <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_pipe_start <= 1'b0;
            r_pipe_dataa <= '0;
            r_err        <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            if (w_accept_cmd) begin
                r_len        <= cmd_len;
                r_issued_cnt <= '0;
                r_popped_cnt <= '0;
                r_inflight   <= '0;
            end else begin
                if (w_issue) r_issued_cnt <= r_issued_cnt + LEN_W'(1);
                if (w_pop)   r_popped_cnt <= r_popped_cnt + LEN_W'(1);
                case ({w_issue, w_wr})
                    2'b10:   r_inflight <= r_inflight + c_cnt_w'(1);
                    2'b01:   r_inflight <= r_inflight - c_cnt_w'(1);
                    default: r_inflight <= r_inflight;
                endcase
            end

            if (w_wr)  r_wr_ptr <= r_wr_ptr + c_addr_w'(1);
            if (w_pop) r_rd_ptr <= r_rd_ptr + c_addr_w'(1);
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase

            r_pipe_start <= w_issue;
            if (w_issue) r_pipe_dataa <= in_data;

            // A result with no outstanding credit means the unit and the
            // scheduler disagree; flag it and never let it corrupt the FIFO.
            if (pipe_done && ((r_inflight == '0) || w_full)) r_err <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (w_wr) r_mem[r_wr_ptr] <= pipe_result;
    end

endmodule
`default_nettype wire

// File: tb/tb_inner_fn_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_inner_fn_sched
// Description : Self-checking bench for inner_fn_sched with a queue-based
//               reference model and a fixed-latency stand-in for the unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inner_fn_sched;

    localparam int PIPE_LATENCY = 15;
    localparam int FIFO_DEPTH   = 16;
    localparam int LEN_W        = 16;

    logic             clock;
    logic             aclr_n;
    logic             cmd_start;
    logic [LEN_W-1:0] cmd_len;
    logic             cmd_busy;
    logic             cmd_done;
    logic             in_valid;
    logic [31:0]      in_data;
    logic             in_ready;
    logic             pipe_aclr;
    logic             pipe_clk_en;
    logic             pipe_start;
    logic [31:0]      pipe_dataa;
    logic [31:0]      pipe_result;
    logic             pipe_done;
    logic             out_valid;
    logic [31:0]      out_data;
    logic             out_last;
    logic             out_ready;
    logic             err_overflow;

    inner_fn_sched #(
        .PIPE_LATENCY(PIPE_LATENCY),
        .FIFO_DEPTH  (FIFO_DEPTH),
        .LEN_W       (LEN_W)
    ) dut (
        .clock       (clock),
        .aclr_n      (aclr_n),
        .cmd_start   (cmd_start),
        .cmd_len     (cmd_len),
        .cmd_busy    (cmd_busy),
        .cmd_done    (cmd_done),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .pipe_aclr   (pipe_aclr),
        .pipe_clk_en (pipe_clk_en),
        .pipe_start  (pipe_start),
        .pipe_dataa  (pipe_dataa),
        .pipe_result (pipe_result),
        .pipe_done   (pipe_done),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_last    (out_last),
        .out_ready   (out_ready),
        .err_overflow(err_overflow)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Known points of 0.5*x + x^2*cos((x-128)/128); other operands get a
    // reversible scramble, since the scheduler only has to forward them.
    function automatic logic [31:0] unit_fn(input logic [31:0] x);
        if (x == 32'h0000_0000) return 32'h0000_0000;
        if (x == 32'h4300_0000) return 32'h4680_8000;
        return {x[15:0], x[31:16]} ^ 32'h5A5A_A5A5;
    endfunction

    logic [PIPE_LATENCY-1:0] u_vld;
    logic [31:0]             u_dat [PIPE_LATENCY];
    logic                    inject_done;

    always @(posedge clock) begin
        if (pipe_aclr) u_vld <= '0;
        else           u_vld <= {u_vld[PIPE_LATENCY-2:0], pipe_start};
        u_dat[0] <= unit_fn(pipe_dataa);
        for (int k = 1; k < PIPE_LATENCY; k++) u_dat[k] <= u_dat[k-1];
    end
    assign pipe_done   = u_vld[PIPE_LATENCY-1] | inject_done;
    assign pipe_result = u_dat[PIPE_LATENCY-1];

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    int feed_mode  = 0;   // 0 off, 1 always, 2 random
    int ready_mode = 0;   // 0 low, 1 high, 2 random
    int data_mode  = 0;   // 0 random, 1 zero, 2 128.0

    initial begin
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            case (feed_mode)
                0:       in_valid = 1'b0;
                1:       in_valid = 1'b1;
                default: in_valid = ($urandom_range(0, 3) != 0);
            endcase
            case (data_mode)
                1:       in_data = 32'h0000_0000;
                2:       in_data = 32'h4300_0000;
                default: in_data = $urandom;
            endcase
            case (ready_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = ($urandom_range(0, 2) != 0);
            endcase
        end
    end

    // Reference model: every accepted operand owes exactly one result, in order.
    logic [31:0] exp_q [$];
    logic [31:0] mon_exp;
    logic [31:0] last_out_data;
    logic        last_out_last;
    int job_len = 0, out_idx = 0, acc_cnt = 0, pop_cnt = 0, done_cnt = 0, busy_cnt = 0;
    int hs_cyc = 0, ps_cyc = 0, pop_first = 0, pop_last = 0, done_cyc = 0;
    int ready_run = 0, ready_run_max = 0, ready_hi_cnt = 0;
    bit err_expect = 0;

    initial begin
        forever begin
            @(negedge clock);
            if (!aclr_n) begin
                exp_q.delete();
                out_idx = 0;
            end else begin
                if (in_valid && in_ready) begin
                    check("credit_bound", 32'(exp_q.size() < FIFO_DEPTH), 32'd1);
                    exp_q.push_back(unit_fn(in_data));
                    acc_cnt++;
                    hs_cyc = cyc;
                end
                if (in_ready) begin
                    ready_hi_cnt++;
                    ready_run++;
                    if (ready_run > ready_run_max) ready_run_max = ready_run;
                end else begin
                    ready_run = 0;
                end
                if (pipe_start) ps_cyc = cyc;
                if (cmd_busy) busy_cnt++;
                if (out_valid && exp_q.size() == 0) begin
                    check("spurious_out_valid", 32'(out_valid), 32'd0);
                end else if (out_valid && out_ready) begin
                    mon_exp = exp_q.pop_front();
                    check("out_data", out_data, mon_exp);
                    check("out_last", 32'(out_last), 32'(out_idx == job_len - 1));
                    last_out_data = out_data;
                    last_out_last = out_last;
                    if (pop_cnt == 0) pop_first = cyc;
                    pop_last = cyc;
                    pop_cnt++;
                    out_idx++;
                end
                if (cmd_done) begin
                    done_cnt++;
                    done_cyc = cyc;
                    check("done_after_all_out", 32'(out_idx), 32'(job_len));
                    check("busy_at_done", 32'(cmd_busy), 32'd1);
                end
                if (!err_expect) check("err_overflow_clear", 32'(err_overflow), 32'd0);
            end
        end
    end

    task automatic start_job(input int n);
        @(posedge clock);
        #1;
        job_len  = n;
        out_idx  = 0;
        pop_cnt  = 0;
        acc_cnt  = 0;
        done_cnt = 0;
        busy_cnt = 0;
        cmd_start = 1'b1;
        cmd_len   = LEN_W'(n);
        @(posedge clock);
        #1;
        cmd_start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int k;
        k = 0;
        while (done_cnt == 0 && k < budget) begin
            @(posedge clock);
            k++;
        end
        check({name, "_done_timeout"}, 32'(done_cnt != 0), 32'd1);
    endtask

    task automatic end_job(input int n, input string name);
        repeat (3) @(posedge clock);
        #1;
        check({name, "_accepted"}, 32'(acc_cnt), 32'(n));
        check({name, "_outputs"}, 32'(pop_cnt), 32'(n));
        check({name, "_model_empty"}, 32'(exp_q.size()), 32'd0);
        check({name, "_done_once"}, 32'(done_cnt), 32'd1);
        check({name, "_busy_fell"}, 32'(cmd_busy), 32'd0);
    endtask

    task automatic check_all_clear(input string name);
        check({name, "_cmd_busy"}, 32'(cmd_busy), 32'd0);
        check({name, "_cmd_done"}, 32'(cmd_done), 32'd0);
        check({name, "_in_ready"}, 32'(in_ready), 32'd0);
        check({name, "_pipe_start"}, 32'(pipe_start), 32'd0);
        check({name, "_pipe_dataa"}, pipe_dataa, 32'd0);
        check({name, "_out_valid"}, 32'(out_valid), 32'd0);
        check({name, "_out_last"}, 32'(out_last), 32'd0);
        check({name, "_err_overflow"}, 32'(err_overflow), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int k;
        bit pd_seen;
        bit ov_seen;
        aclr_n      = 1'b0;
        cmd_start   = 1'b0;
        cmd_len     = '0;
        inject_done = 1'b0;

        // Reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_all_clear("reset");
        check("reset_pipe_aclr", 32'(pipe_aclr), 32'd1);
        check("pipe_clk_en", 32'(pipe_clk_en), 32'd1);
        @(posedge clock);
        #1;
        aclr_n = 1'b1;
        @(negedge clock);
        check("run_pipe_aclr", 32'(pipe_aclr), 32'd0);

        // Single element, latency pinned by literals
        data_mode = 2; feed_mode = 1; ready_mode = 1;
        start_job(1);
        wait_done(60, "n1");
        end_job(1, "n1");
        check("n1_pipe_start_lat", 32'(ps_cyc - hs_cyc), 32'd1);
        check("n1_out_lat", 32'(pop_first - hs_cyc), 32'd17);
        check("n1_out_data", last_out_data, 32'h4680_8000);
        check("n1_out_last", 32'(last_out_last), 32'd1);
        check("n1_done_lat", 32'(done_cyc - pop_last), 32'd1);

        // Four zeros at full rate
        data_mode = 1; ready_run_max = 0; ready_hi_cnt = 0;
        start_job(4);
        wait_done(80, "n4");
        end_job(4, "n4");
        check("n4_ready_run", 32'(ready_run_max), 32'd4);
        check("n4_ready_total", 32'(ready_hi_cnt), 32'd4);
        check("n4_out_span", 32'(pop_last - pop_first), 32'd3);
        check("n4_last_data", last_out_data, 32'h0000_0000);

        // Backpressure: credits stop issue at FIFO_DEPTH
        data_mode = 0; ready_mode = 0;
        start_job(40);
        repeat (60) @(posedge clock);
        #1;
        check("bp_accepts_stalled", 32'(acc_cnt), 32'd16);
        check("bp_no_pops", 32'(pop_cnt), 32'd0);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        ready_mode = 1;
        wait_done(300, "bp");
        end_job(40, "bp");

        // Zero-length job
        ready_hi_cnt = 0;
        start_job(0);
        wait_done(10, "n0");
        repeat (3) @(posedge clock);
        #1;
        check("n0_no_in_ready", 32'(ready_hi_cnt), 32'd0);
        check("n0_done_once", 32'(done_cnt), 32'd1);
        check("n0_busy_cycles", 32'(busy_cnt), 32'd1);
        check("n0_no_output", 32'(pop_cnt), 32'd0);

        // cmd_start while busy is ignored
        feed_mode = 2; ready_mode = 2;
        start_job(3);
        repeat (3) @(posedge clock);
        #1;
        cmd_start = 1'b1;
        cmd_len   = LEN_W'(7);
        @(posedge clock);
        #1;
        cmd_start = 1'b0;
        wait_done(200, "ign");
        end_job(3, "ign");

        // Reset in the middle of a job
        feed_mode = 1; ready_mode = 1;
        start_job(5);
        k = 0;
        while (acc_cnt < 3 && k < 50) begin
            @(posedge clock);
            k++;
        end
        check("mid_reach_3", 32'(acc_cnt >= 3), 32'd1);
        #1;
        aclr_n = 1'b0;
        @(posedge clock);
        #1;
        aclr_n    = 1'b1;
        feed_mode = 0;
        @(negedge clock);
        check_all_clear("mid_reset");
        pd_seen = 0;
        ov_seen = 0;
        repeat (20) begin
            @(negedge clock);
            pd_seen |= pipe_done;
            ov_seen |= out_valid;
        end
        check("mid_no_pipe_done", 32'(pd_seen), 32'd0);
        check("mid_no_out_valid", 32'(ov_seen), 32'd0);
        feed_mode = 1;
        start_job(1);
        wait_done(60, "post_reset");
        end_job(1, "post_reset");

        // Randomized jobs
        feed_mode = 2; ready_mode = 2; data_mode = 0;
        for (int j = 0; j < 6; j++) begin
            n = int'($urandom_range(1, 50));
            start_job(n);
            wait_done(n * 10 + 100, "rand");
            end_job(n, "rand");
        end
        feed_mode = 0;

        // Spurious pipe_done while idle sets the sticky error
        err_expect = 1;
        @(posedge clock);
        #1;
        inject_done = 1'b1;
        @(posedge clock);
        #1;
        inject_done = 1'b0;
        @(negedge clock);
        check("err_set", 32'(err_overflow), 32'd1);
        repeat (5) @(posedge clock);
        @(negedge clock);
        check("err_sticky", 32'(err_overflow), 32'd1);
        @(posedge clock);
        #1;
        aclr_n = 1'b0;
        @(posedge clock);
        #1;
        aclr_n = 1'b1;
        @(negedge clock);
        check("err_cleared_by_reset", 32'(err_overflow), 32'd0);
        err_expect = 0;
        repeat (3) @(posedge clock);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
